// File: rtl/sky_frame_ctrl_if.sv
// Control bundle between the sky frame scheduler and its environment.
// master drives enable/finish_drawing; slave is the scheduler itself.
interface sky_frame_ctrl_if;
    logic        enable;
    logic        finish_drawing;
    logic        update;
    logic        draw;
    logic        plot;
    logic        busy;
    logic [15:0] frame_count;
    logic [7:0]  skipped;
    logic        wdog_err;

    modport master (
        output enable,
        output finish_drawing,
        input  update,
        input  draw,
        input  plot,
        input  busy,
        input  frame_count,
        input  skipped,
        input  wdog_err
    );

    modport slave (
        input  enable,
        input  finish_drawing,
        output update,
        output draw,
        output plot,
        output busy,
        output frame_count,
        output skipped,
        output wdog_err
    );
endinterface

// File: rtl/sky_frame_ctrl.sv
// Frame scheduler upstream of the sky scroller: frame ticks, scroll pulse, draw/plot.
// Optional draw watchdog is enabled by defining SKY_FRAME_WATCHDOG_EN.
module sky_frame_ctrl #(
    parameter int TICKS_PER_FRAME = 833333,
    parameter int FRAMES_PER_STEP = 15,
    parameter int CNT_W           = 20,
    parameter int WDOG_CYCLES     = 4096
) (
    input  logic             clock,
    input  logic             reset,
    sky_frame_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        UPDATE,
        SETTLE,
        DRAW,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] TICK_MAX  = CNT_W'(TICKS_PER_FRAME - 1);
    localparam logic [7:0]       STEP_LAST = 8'(FRAMES_PER_STEP - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_tick_cnt;
    logic [7:0]        r_step_cnt;
    logic [15:0]       r_frame_cnt;
    logic [7:0]        r_skipped;
    logic              r_draw_q;
    logic              w_tick;
    logic              w_step_adv;
    logic              w_step_clr;
    logic              w_skip;
    logic              w_draw;
    logic              w_wdog_trip;

    assign w_tick = (r_tick_cnt == '0);
    assign w_draw = (r_state == DRAW);

`ifdef SKY_FRAME_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] r_wdog_cnt;
    logic              r_wdog_err;

    // Count cycles spent in DRAW; held at zero elsewhere so DRAW entry starts fresh.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wdog_cnt <= '0;
        end else if (w_draw && w_state_nxt == DRAW) begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
        end else begin
            r_wdog_cnt <= '0;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wdog_err <= 1'b0;
        end else if (w_wdog_trip) begin
            r_wdog_err <= 1'b1;
        end
    end

    assign bus.wdog_err = r_wdog_err;
`else
    logic w_unused_wdog;
    assign w_unused_wdog = |WDOG_CYCLES;
    assign bus.wdog_err  = 1'b0;
`endif

    // Free-running frame tick divider, active in every state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= TICK_MAX;
        end else if (w_tick) begin
            r_tick_cnt <= TICK_MAX;
        end else begin
            r_tick_cnt <= r_tick_cnt - 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic plus step/overrun/watchdog strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_step_adv  = 1'b0;
        w_step_clr  = 1'b0;
        w_skip      = 1'b0;
        w_wdog_trip = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.enable) w_state_nxt = WAIT_TICK;
            end
            WAIT_TICK: begin
                if (!bus.enable) begin
                    w_state_nxt = IDLE;
                end else if (w_tick) begin
                    if (r_step_cnt == STEP_LAST) begin
                        w_step_clr  = 1'b1;
                        w_state_nxt = UPDATE;
                    end else begin
                        w_step_adv  = 1'b1;
                        w_state_nxt = DRAW;
                    end
                end
            end
            UPDATE: begin
                w_skip      = w_tick;
                w_state_nxt = SETTLE;
            end
            SETTLE: begin
                w_skip      = w_tick;
                w_state_nxt = DRAW;
            end
            DRAW: begin
                w_skip = w_tick;
                if (bus.finish_drawing) begin
                    w_state_nxt = DONE;
                end
`ifdef SKY_FRAME_WATCHDOG_EN
                else if (r_wdog_cnt == WDOG_LAST) begin
                    w_wdog_trip = 1'b1;
                    w_state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                w_skip      = w_tick;
                w_state_nxt = bus.enable ? WAIT_TICK : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Frames-between-scroll counter, only moved by ticks seen in WAIT_TICK.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_step_cnt <= '0;
        end else if (w_step_clr) begin
            r_step_cnt <= '0;
        end else if (w_step_adv) begin
            r_step_cnt <= r_step_cnt + 1'b1;
        end
    end

    // Frame counter (wrapping) and saturating overrun counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_frame_cnt <= '0;
            r_skipped   <= '0;
        end else begin
            if (w_tick) r_frame_cnt <= r_frame_cnt + 1'b1;
            if (w_skip && r_skipped != 8'hFF) r_skipped <= r_skipped + 1'b1;
        end
    end

    // draw delayed one cycle so the drawer's first output is registered before plotting.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_draw_q <= 1'b0;
        end else begin
            r_draw_q <= w_draw;
        end
    end

    assign bus.update      = (r_state == UPDATE);
    assign bus.draw        = w_draw;
    assign bus.plot        = r_draw_q & w_draw & ~bus.finish_drawing;
    assign bus.busy        = (r_state != IDLE) && (r_state != WAIT_TICK);
    assign bus.frame_count = r_frame_cnt;
    assign bus.skipped     = r_skipped;

endmodule
